// File: rtl/spi_write_commit_pkg.sv
// Shared definitions for the SPI write-commit engine: opcodes, status-register
// bit positions and the FSM encoding.
package spi_write_commit_pkg;

  localparam logic [7:0] SPI_CMD_PP3   = 8'h02;
  localparam logic [7:0] SPI_CMD_ERASE = 8'h20;

  localparam int WEL = 0;
  localparam int WIP = 1;

  // Status-register bits cleared when a job commits.
  localparam logic [7:0] SR_CLEAR_MASK = ~(8'(1 << WEL) | 8'(1 << WIP));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_REQ,
    ST_DONE
  } state_t;

  typedef enum logic {
    JOB_PP3,
    JOB_ERASE
  } job_t;

endpackage

// File: rtl/spi_write_commit.sv
// Commits logged SPI page-program and sector-erase commands into PSRAM,
// one byte per RD/WAIT/REQ pass, then clears WEL/WIP in the status register.
module spi_write_commit
  import spi_write_commit_pkg::*;
#(
  parameter int BUF_DEPTH   = 256,
  parameter int ERASE_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd_in,
  input  logic [31:0] addr_in,
  input  logic [11:0] len_in,
  input  logic        cmd_strobe,
  input  logic [7:0]  sr_in,
  output logic [7:0]  sr_out,
  output logic        sr_strobe,
  output logic [7:0]  buf_raddr,
  input  logic [7:0]  buf_rdata,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        busy,
  output logic        cmd_drop
);

  localparam int MAX_BYTES = (BUF_DEPTH > ERASE_BYTES) ? BUF_DEPTH : ERASE_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam logic [23:0] ERASE_MASK = 24'(ERASE_BYTES - 1);

  state_t           state, state_nxt;
  job_t             job;
  logic [23:0]      start;
  logic [CNT_W-1:0] idx, count;

  logic             is_pp3, is_erase, accept, handshake, last_byte;
  logic [11:0]      pp3_bytes;
  logic [CNT_W-1:0] pp3_n, idx_inc;
  logic [23:0]      byte_addr;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^addr_in[31:24];

  assign is_pp3    = (cmd_in == SPI_CMD_PP3);
  assign is_erase  = (cmd_in == SPI_CMD_ERASE);
  assign accept    = cmd_strobe && (is_pp3 || is_erase);
  assign handshake = mem_valid && mem_ready;
  assign idx_inc   = idx + CNT_W'(1);
  assign last_byte = (idx_inc == count);
  assign busy      = (state != ST_IDLE);

  // Program length excludes opcode + 3 address bytes, capped at the buffer size.
  assign pp3_bytes = len_in - 12'd4;
  assign pp3_n     = (len_in <= 12'd4)                        ? '0 :
                     (32'(pp3_bytes) > 32'(BUF_DEPTH))        ? CNT_W'(BUF_DEPTH) :
                                                                CNT_W'(pp3_bytes);

  // Page programs wrap inside the 256-byte page; erases walk linearly.
  assign byte_addr = (job == JOB_PP3) ? {start[23:8], start[7:0] + 8'(idx)}
                                      : start + 24'(idx);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!sr_in[WEL] || (is_pp3 && pp3_n == '0)) state_nxt = ST_DONE;
          else                                        state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_REQ;
      ST_REQ: begin
        if (handshake) state_nxt = last_byte ? ST_DONE : ST_RD;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      job       <= JOB_PP3;
      start     <= '0;
      idx       <= '0;
      count     <= '0;
      sr_out    <= '0;
      sr_strobe <= 1'b0;
      cmd_drop  <= 1'b0;
      buf_raddr <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr_strobe <= 1'b0;
      cmd_drop  <= cmd_strobe && busy;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            job       <= is_erase ? JOB_ERASE : JOB_PP3;
            start     <= is_erase ? (addr_in[23:0] & ~ERASE_MASK) : addr_in[23:0];
            count     <= is_erase ? CNT_W'(ERASE_BYTES) : pp3_n;
            idx       <= '0;
            buf_raddr <= '0;
          end
        end
        ST_WAIT: begin
          mem_valid <= 1'b1;
          mem_addr  <= byte_addr;
          mem_data  <= (job == JOB_PP3) ? buf_rdata : 8'hFF;
        end
        ST_REQ: begin
          if (handshake) begin
            mem_valid <= 1'b0;
            idx       <= idx_inc;
            buf_raddr <= 8'(idx_inc);
          end
        end
        ST_DONE: begin
          sr_strobe <= 1'b1;
          sr_out    <= sr_in & SR_CLEAR_MASK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_write_commit.sv
// Directed bench for spi_write_commit: program, page wrap, erase, WEL clear,
// backpressure with command drop, and reset in the middle of an erase.
module tb_spi_write_commit;
  import spi_write_commit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cmd_in;
  logic [31:0] addr_in;
  logic [11:0] len_in;
  logic        cmd_strobe;
  logic [7:0]  sr_in;
  logic [7:0]  sr_out;
  logic        sr_strobe;
  logic [7:0]  buf_raddr;
  logic [7:0]  buf_rdata;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        busy;
  logic        cmd_drop;

  int checks = 0;
  int errors = 0;

  spi_write_commit #(.BUF_DEPTH(256), .ERASE_BYTES(4096)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_in     (cmd_in),
    .addr_in    (addr_in),
    .len_in     (len_in),
    .cmd_strobe (cmd_strobe),
    .sr_in      (sr_in),
    .sr_out     (sr_out),
    .sr_strobe  (sr_strobe),
    .buf_raddr  (buf_raddr),
    .buf_rdata  (buf_rdata),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .cmd_drop   (cmd_drop)
  );

  always #5 clk = ~clk;

  // External write buffer with one cycle of read latency.
  logic [7:0] buf_mem [256];
  always @(posedge clk) buf_rdata <= buf_mem[buf_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  logic [23:0] hs_addr [$];
  logic [7:0]  hs_data [$];
  int          hs_cyc  [$];
  int          sr_count = 0, last_sr_cyc = 0, drop_count = 0, valid_cycles = 0, cmd_cyc = 0;
  logic [7:0]  last_sr_out = '0;
  logic        prev_pending = 1'b0;
  logic [23:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) cmd_cyc = cyc;
    if (mem_valid === 1'b1) valid_cycles++;
    if (prev_pending && mem_valid === 1'b1) begin
      check("hold_addr", 32'(mem_addr), 32'(prev_addr));
      check("hold_data", 32'(mem_data), 32'(prev_data));
    end
    prev_pending = (mem_valid === 1'b1) && (mem_ready !== 1'b1);
    prev_addr    = mem_addr;
    prev_data    = mem_data;
    if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
      hs_addr.push_back(mem_addr);
      hs_data.push_back(mem_data);
      hs_cyc.push_back(cyc);
    end
    if (sr_strobe === 1'b1) begin
      sr_count++;
      last_sr_out = sr_out;
      last_sr_cyc = cyc;
    end
    if (cmd_drop === 1'b1) drop_count++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cmd, input logic [31:0] addr, input logic [11:0] len);
    cmd_in     = cmd;
    addr_in    = addr;
    len_in     = len;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
  endtask

  task automatic clear_log;
    hs_addr.delete();
    hs_data.delete();
    hs_cyc.delete();
  endtask

  task automatic wait_done(input int prev_sr, input int budget, input string tag);
    int n = 0;
    while (sr_count == prev_sr && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(sr_count), 32'(prev_sr + 1));
    tick(2);
  endtask

  initial begin
    int s0, v0, d0, n, bad;

    reset      = 1'b1;
    cmd_in     = '0;
    addr_in    = '0;
    len_in     = '0;
    cmd_strobe = 1'b0;
    sr_in      = '0;
    mem_ready  = 1'b1;
    for (int i = 0; i < 256; i++) buf_mem[i] = 8'(i);
    #2 reset = 1'b0;
    tick(3);

    check("rst_busy",      32'(busy),      32'h0);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_sr_strobe", 32'(sr_strobe), 32'h0);
    check("rst_cmd_drop",  32'(cmd_drop),  32'h0);
    check("rst_sr_out",    32'(sr_out),    32'h0);
    check("rst_buf_raddr", 32'(buf_raddr), 32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_data",  32'(mem_data),  32'h0);
    reset = 1'b1;
    tick(2);

    // Basic page program of four bytes.
    buf_mem[0] = 8'hAA; buf_mem[1] = 8'hBB; buf_mem[2] = 8'hCC; buf_mem[3] = 8'hDD;
    sr_in = 8'h03;
    clear_log();
    s0 = sr_count;
    send(SPI_CMD_PP3, 32'h000012F0, 12'd8);
    wait_done(s0, 100, "pp3_done");
    check("pp3_count", 32'(hs_addr.size()), 32'd4);
    check("pp3_a0", 32'(hs_addr[0]), 32'h0012F0);
    check("pp3_a1", 32'(hs_addr[1]), 32'h0012F1);
    check("pp3_a2", 32'(hs_addr[2]), 32'h0012F2);
    check("pp3_a3", 32'(hs_addr[3]), 32'h0012F3);
    check("pp3_d0", 32'(hs_data[0]), 32'hAA);
    check("pp3_d1", 32'(hs_data[1]), 32'hBB);
    check("pp3_d2", 32'(hs_data[2]), 32'hCC);
    check("pp3_d3", 32'(hs_data[3]), 32'hDD);
    check("pp3_latency",    32'(hs_cyc[0] - cmd_cyc), 32'd3);
    check("pp3_throughput", 32'(hs_cyc[3] - hs_cyc[0]), 32'd9);
    check("pp3_sr_delay",   32'(last_sr_cyc - hs_cyc[3]), 32'd2);
    check("pp3_sr_out",     32'(last_sr_out), 32'h00);

    // Page wrap: address low byte wraps without carrying into bit 8.
    clear_log();
    s0 = sr_count;
    send(SPI_CMD_PP3, 32'h000001FE, 12'd8);
    wait_done(s0, 100, "wrap_done");
    check("wrap_count", 32'(hs_addr.size()), 32'd4);
    check("wrap_a0", 32'(hs_addr[0]), 32'h0001FE);
    check("wrap_a1", 32'(hs_addr[1]), 32'h0001FF);
    check("wrap_a2", 32'(hs_addr[2]), 32'h000100);
    check("wrap_a3", 32'(hs_addr[3]), 32'h000101);
    check("wrap_d2", 32'(hs_data[2]), 32'hCC);

    // WEL clear: straight to DONE, strobe two cycles after the command.
    sr_in = 8'h02;
    s0 = sr_count;
    v0 = valid_cycles;
    send(SPI_CMD_PP3, 32'h00000100, 12'd8);
    wait_done(s0, 20, "nowel_done");
    check("nowel_no_valid", 32'(valid_cycles), 32'(v0));
    check("nowel_sr_delay", 32'(last_sr_cyc - cmd_cyc), 32'd2);
    check("nowel_sr_out",   32'(last_sr_out), 32'h00);

    // Upper status bits pass through untouched.
    sr_in = 8'hF2;
    s0 = sr_count;
    send(SPI_CMD_ERASE, 32'h00000000, 12'd4);
    wait_done(s0, 20, "nowel_erase_done");
    check("nowel_erase_no_valid", 32'(valid_cycles), 32'(v0));
    check("sr_mask_upper", 32'(last_sr_out), 32'hF0);

    // PP3 with only opcode + address bytes: no data, commit anyway.
    sr_in = 8'h43;
    s0 = sr_count;
    send(SPI_CMD_PP3, 32'h00000000, 12'd4);
    wait_done(s0, 20, "len4_done");
    check("len4_no_valid", 32'(valid_cycles), 32'(v0));
    check("len4_sr_out",   32'(last_sr_out), 32'h40);

    // Unknown opcode is ignored outright.
    sr_in = 8'h03;
    s0 = sr_count;
    send(8'h9F, 32'h00000000, 12'd8);
    check("unk_busy", 32'(busy), 32'h0);
    tick(6);
    check("unk_no_sr", 32'(sr_count), 32'(s0));
    check("unk_no_valid", 32'(valid_cycles), 32'(v0));

    // A command landing in the DONE cycle is dropped.
    sr_in = 8'h02;
    s0 = sr_count;
    d0 = drop_count;
    send(SPI_CMD_PP3, 32'h00000000, 12'd8);
    send(SPI_CMD_PP3, 32'h00000000, 12'd8);
    tick(6);
    check("done_drop", 32'(drop_count), 32'(d0 + 1));
    check("done_drop_single_sr", 32'(sr_count), 32'(s0 + 1));

    // Backpressure with a second command arriving mid-job.
    sr_in = 8'h03;
    buf_mem[0] = 8'h11; buf_mem[1] = 8'h22;
    mem_ready = 1'b0;
    clear_log();
    s0 = sr_count;
    d0 = drop_count;
    send(SPI_CMD_PP3, 32'h00000400, 12'd6);
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid_up", 32'(mem_valid), 32'h1);
    tick(2);
    send(SPI_CMD_ERASE, 32'h00000000, 12'd0);
    tick(2);
    check("bp_valid_held", 32'(mem_valid), 32'h1);
    mem_ready = 1'b1;
    wait_done(s0, 100, "bp_done");
    tick(10);
    check("bp_drop",     32'(drop_count), 32'(d0 + 1));
    check("bp_one_sr",   32'(sr_count), 32'(s0 + 1));
    check("bp_count",    32'(hs_addr.size()), 32'd2);
    check("bp_a0",       32'(hs_addr[0]), 32'h000400);
    check("bp_a1",       32'(hs_addr[1]), 32'h000401);
    check("bp_d0",       32'(hs_data[0]), 32'h11);
    check("bp_d1",       32'(hs_data[1]), 32'h22);
    check("bp_sr_out",   32'(last_sr_out), 32'h00);

    // Full sector erase, aligned down to 4 KiB.
    clear_log();
    s0 = sr_count;
    send(SPI_CMD_ERASE, 32'h00123456, 12'd4);
    wait_done(s0, 13000, "erase_done");
    check("erase_count", 32'(hs_addr.size()), 32'd4096);
    bad = 0;
    for (int i = 0; i < hs_addr.size(); i++)
      if (hs_addr[i] !== 24'h123000 + 24'(i) || hs_data[i] !== 8'hFF) bad++;
    check("erase_pattern", 32'(bad), 32'd0);
    check("erase_first", 32'(hs_addr[0]), 32'h123000);
    check("erase_last",  32'(hs_addr[4095]), 32'h123FFF);
    check("erase_sr_out", 32'(last_sr_out), 32'h00);

    // Reset in the middle of an erase abandons the job.
    clear_log();
    s0 = sr_count;
    send(SPI_CMD_ERASE, 32'h000456AB, 12'd4);
    n = 0;
    while (hs_addr.size() < 100 && n < 1000) begin
      tick();
      n++;
    end
    check("mid_reached_100", 32'(hs_addr.size()), 32'd100);
    check("mid_erase_base", 32'(hs_addr[0]), 32'h045000);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(mem_valid), 32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    check("mid_rst_raddr", 32'(buf_raddr), 32'h0);
    check("mid_rst_maddr", 32'(mem_addr),  32'h0);
    tick(3);
    reset = 1'b1;
    tick(20);
    check("mid_no_sr", 32'(sr_count), 32'(s0));

    buf_mem[0] = 8'h5A; buf_mem[1] = 8'hA5;
    clear_log();
    send(SPI_CMD_PP3, 32'h00000010, 12'd6);
    wait_done(s0, 100, "post_rst_done");
    check("post_count", 32'(hs_addr.size()), 32'd2);
    check("post_a0", 32'(hs_addr[0]), 32'h000010);
    check("post_a1", 32'(hs_addr[1]), 32'h000011);
    check("post_d0", 32'(hs_data[0]), 32'h5A);
    check("post_d1", 32'(hs_data[1]), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
